// File: rtl/store_unit_if.sv
// Issue-side request and memory write-port signals of the store unit.
// The slave modport is the store unit; master is the issue stage / memory environment.
interface store_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned NB = XLEN / 8;

  logic              in_valid;
  logic              in_ready;
  logic [24:0]       instruction_code;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [NB-1:0]     mem_be;
  logic              mem_ack;
  logic              done;
  logic              fault;
  logic              busy;

  modport master (
    output in_valid, instruction_code, rs1_val, rs2_val, mem_req_ready, mem_ack,
    input  in_ready, mem_req_valid, mem_addr, mem_wdata, mem_be, done, fault, busy
  );

  modport slave (
    input  in_valid, instruction_code, rs1_val, rs2_val, mem_req_ready, mem_ack,
    output in_ready, mem_req_valid, mem_addr, mem_wdata, mem_be, done, fault, busy
  );
endinterface

// File: rtl/store_unit.sv
// Store execution unit: decodes an S-type store, aligns data/byte enables and
// issues one or two write beats on a valid/ready memory port.
module store_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned MISALIGN_SPLIT = 1
) (
  input logic         clk,
  input logic         rst,
  store_unit_if.slave bus
);
  localparam int unsigned NB  = XLEN / 8;
  localparam int unsigned OFF = $clog2(NB);

  typedef enum logic [2:0] {StIdle, StReq1, StWait1, StReq2, StWait2, StFlt} state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic              mem_req_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [NB-1:0]     mem_be_q;
  logic              done_q;
  logic              fault_q;
  logic              busy_q;
  logic              crossing_q;
  logic [NB-1:0]     be_hi_q;
  logic [XLEN-1:0]   wdata_hi_q;

  logic [2:0]        func3;
  logic [11:0]       imm;
  logic [XLEN-1:0]   ea;
  logic [OFF-1:0]    off;
  logic [3:0]        nbytes;
  logic [NB-1:0]     size_mask;
  logic              legal;
  logic              crossing;
  logic [2*NB-1:0]   be_wide;
  logic [2*XLEN-1:0] wdata_wide;
  logic              unused_bits;

  assign unused_bits = ^bus.instruction_code[17:8];

  // Shifting into a double-width vector yields beat1 in the low half and the
  // spill-over for beat2 in the high half.
  always_comb begin
    func3      = bus.instruction_code[7:5];
    imm        = {bus.instruction_code[24:18], bus.instruction_code[4:0]};
    ea         = bus.rs1_val + {{(XLEN-12){imm[11]}}, imm};
    off        = ea[OFF-1:0];
    nbytes     = 4'd1 << func3[1:0];
    size_mask  = NB'((16'd1 << nbytes) - 16'd1);
    legal      = (func3 <= 3'd2) || ((func3 == 3'd3) && (XLEN == 64));
    crossing   = (32'(off) + 32'(nbytes)) > NB;
    be_wide    = {{NB{1'b0}}, size_mask} << off;
    wdata_wide = {{XLEN{1'b0}}, bus.rs2_val} << {off, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      in_ready_q      <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_be_q        <= '0;
      done_q          <= 1'b0;
      fault_q         <= 1'b0;
      busy_q          <= 1'b0;
      crossing_q      <= 1'b0;
      be_hi_q         <= '0;
      wdata_hi_q      <= '0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            crossing_q <= crossing;
            be_hi_q    <= be_wide[2*NB-1:NB];
            wdata_hi_q <= wdata_wide[2*XLEN-1:XLEN];
            if (!legal || (crossing && (MISALIGN_SPLIT == 0))) begin
              state_q <= StFlt;
              fault_q <= 1'b1;
            end else begin
              state_q         <= StReq1;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= {ea[ADDR_W-1:OFF], {OFF{1'b0}}};
              mem_wdata_q     <= wdata_wide[XLEN-1:0];
              mem_be_q        <= be_wide[NB-1:0];
            end
          end
        end
        StReq1: begin
          if (bus.mem_req_ready) begin
            state_q         <= StWait1;
            mem_req_valid_q <= 1'b0;
          end
        end
        StWait1: begin
          if (bus.mem_ack) begin
            if (crossing_q) begin
              state_q         <= StReq2;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= mem_addr_q + ADDR_W'(NB);
              mem_wdata_q     <= wdata_hi_q;
              mem_be_q        <= be_hi_q;
            end else begin
              state_q    <= StIdle;
              done_q     <= 1'b1;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end
          end
        end
        StReq2: begin
          if (bus.mem_req_ready) begin
            state_q         <= StWait2;
            mem_req_valid_q <= 1'b0;
          end
        end
        StWait2: begin
          if (bus.mem_ack) begin
            state_q    <= StIdle;
            done_q     <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q         <= StIdle;
          mem_req_valid_q <= 1'b0;
          in_ready_q      <= 1'b1;
          busy_q          <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_be        = mem_be_q;
  assign bus.done          = done_q;
  assign bus.fault         = fault_q;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: vector table on a 32-bit split instance with a memory
// responder feeding a beat scoreboard, plus no-split and 64-bit instances.
module tb_store_unit;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } beat_t;

  typedef struct {
    logic [2:0]  func3;
    logic [11:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        exp_fault;
    int          nbeats;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [3:0]  b1;
    logic [31:0] a2;
    logic [31:0] d2;
    logic [3:0]  b2;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_unit_if #(.XLEN(32), .ADDR_W(32)) a_if ();
  store_unit_if #(.XLEN(32), .ADDR_W(32)) b_if ();
  store_unit_if #(.XLEN(64), .ADDR_W(32)) c_if ();

  store_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_a (
    .clk (clk), .rst (rst), .bus (a_if.slave));
  store_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) u_b (
    .clk (clk), .rst (rst), .bus (b_if.slave));
  store_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_c (
    .clk (clk), .rst (rst), .bus (c_if.slave));

  logic  resp_ready = 1'b0;
  logic  resp_ack   = 1'b0;
  logic  tb_ack     = 1'b0;
  logic  ack_en     = 1'b1;
  int    stall_req  = 0;
  int    beat_cnt   = 0;
  int    done_cnt   = 0;
  int    fault_cnt  = 0;
  int    b_fault_cnt = 0;
  int    b_valid_cnt = 0;
  int    n_chk = 0;
  int    n_err = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  vec_t  vecs[12];

  assign a_if.mem_req_ready = resp_ready;
  assign a_if.mem_ack       = resp_ack | tb_ack;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] mk_ic(input logic [2:0] f3, input logic [11:0] imm);
    return {imm[11:5], 5'd7, 5'd3, f3, imm[4:0]};
  endfunction

  always @(negedge clk) begin
    if (a_if.done) done_cnt <= done_cnt + 1;
    if (a_if.fault) fault_cnt <= fault_cnt + 1;
    if (b_if.fault) b_fault_cnt <= b_fault_cnt + 1;
    if (b_if.mem_req_valid) b_valid_cnt <= b_valid_cnt + 1;
  end

  // Memory responder for instance A: optional stall, accept, then one-cycle ack.
  initial begin
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (a_if.mem_req_valid && !rst) begin
        for (int k = 0; k < stall_req; k++) @(negedge clk);
        obs_q.push_back({a_if.mem_addr, a_if.mem_wdata, a_if.mem_be});
        beat_cnt++;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        resp_ack   = ack_en;
      end
    end
  end

  task automatic issue_a(input logic [2:0] f3, input logic [11:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2);
    int t = 0;
    while (!a_if.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!a_if.in_ready) chk("in_ready_wait", 0, 1);
    a_if.instruction_code = mk_ic(f3, imm);
    a_if.rs1_val  = rs1;
    a_if.rs2_val  = rs2;
    a_if.in_valid = 1'b1;
    @(negedge clk);
    a_if.in_valid = 1'b0;
    a_if.instruction_code = 25'($urandom);
    a_if.rs1_val = $urandom;
    a_if.rs2_val = $urandom;
  endtask

  task automatic wait_end_a(input string name);
    int t = 0;
    while (!(a_if.done || a_if.fault) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!(a_if.done || a_if.fault)) chk({name, " timeout"}, 0, 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic cmp_beats(input string name);
    int i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      chk($sformatf("%s beat%0d", name, i), obs_q.pop_front(), exp_q.pop_front());
      i++;
    end
    chk({name, " leftover"}, exp_q.size() + obs_q.size(), 0);
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin : main
    int d0, f0, b0, t;

    vecs[0]  = '{3'd2, 12'h000, 32'h100, 32'hDEADBEEF, 1'b0, 1,
                 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 32'h0, 4'h0};
    vecs[1]  = '{3'd0, 12'h003, 32'h100, 32'h000000AB, 1'b0, 1,
                 32'h100, 32'hAB000000, 4'h8, 32'h0, 32'h0, 4'h0};
    vecs[2]  = '{3'd1, 12'h003, 32'h100, 32'h00001234, 1'b0, 2,
                 32'h100, 32'h34000000, 4'h8, 32'h104, 32'h00000012, 4'h1};
    vecs[3]  = '{3'd2, 12'hFFC, 32'h200, 32'hCAFEF00D, 1'b0, 1,
                 32'h1FC, 32'hCAFEF00D, 4'hF, 32'h0, 32'h0, 4'h0};
    vecs[4]  = '{3'd3, 12'h000, 32'h100, 32'h12345678, 1'b1, 0,
                 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
    vecs[5]  = '{3'd5, 12'h000, 32'h100, 32'h12345678, 1'b1, 0,
                 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
    vecs[6]  = '{3'd2, 12'h000, 32'h102, 32'h11223344, 1'b0, 2,
                 32'h100, 32'h33440000, 4'hC, 32'h104, 32'h00001122, 4'h3};
    vecs[7]  = '{3'd1, 12'h000, 32'h101, 32'h0000ABCD, 1'b0, 1,
                 32'h100, 32'h00ABCD00, 4'h6, 32'h0, 32'h0, 4'h0};
    vecs[8]  = '{3'd0, 12'hFFF, 32'h0, 32'h0000005A, 1'b0, 1,
                 32'hFFFFFFFC, 32'h5A000000, 4'h8, 32'h0, 32'h0, 4'h0};
    vecs[9]  = '{3'd2, 12'h000, 32'hFFFFFFFE, 32'hA1B2C3D4, 1'b0, 2,
                 32'hFFFFFFFC, 32'hC3D40000, 4'hC, 32'h0, 32'h0000A1B2, 4'h3};
    vecs[10] = '{3'd1, 12'h000, 32'h102, 32'h0000BEEF, 1'b0, 1,
                 32'h100, 32'hBEEF0000, 4'hC, 32'h0, 32'h0, 4'h0};
    vecs[11] = '{3'd0, 12'h7FF, 32'h1000, 32'h00000077, 1'b0, 1,
                 32'h17FC, 32'h77000000, 4'h8, 32'h0, 32'h0, 4'h0};

    a_if.in_valid = 1'b0; a_if.instruction_code = '0; a_if.rs1_val = '0; a_if.rs2_val = '0;
    b_if.in_valid = 1'b0; b_if.instruction_code = '0; b_if.rs1_val = '0; b_if.rs2_val = '0;
    b_if.mem_req_ready = 1'b1; b_if.mem_ack = 1'b0;
    c_if.in_valid = 1'b0; c_if.instruction_code = '0; c_if.rs1_val = '0; c_if.rs2_val = '0;
    c_if.mem_req_ready = 1'b0; c_if.mem_ack = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready", a_if.in_ready, 1);
    chk("rst valid/done/fault/busy",
        {a_if.mem_req_valid, a_if.done, a_if.fault, a_if.busy}, 4'b0000);
    chk("rst addr/wdata/be", {a_if.mem_addr, a_if.mem_wdata, a_if.mem_be}, 0);
    chk("rst c in_ready", c_if.in_ready, 1);

    for (int i = 0; i < 12; i++) begin
      d0 = done_cnt; f0 = fault_cnt; b0 = beat_cnt;
      if (vecs[i].nbeats > 0) exp_q.push_back({vecs[i].a1, vecs[i].d1, vecs[i].b1});
      if (vecs[i].nbeats > 1) exp_q.push_back({vecs[i].a2, vecs[i].d2, vecs[i].b2});
      issue_a(vecs[i].func3, vecs[i].imm, vecs[i].rs1, vecs[i].rs2);
      wait_end_a($sformatf("v%0d", i));
      chk($sformatf("v%0d done", i), done_cnt - d0, vecs[i].exp_fault ? 0 : 1);
      chk($sformatf("v%0d fault", i), fault_cnt - f0, vecs[i].exp_fault ? 1 : 0);
      chk($sformatf("v%0d nbeats", i), beat_cnt - b0, vecs[i].nbeats);
      cmp_beats($sformatf("v%0d", i));
    end

    // Backpressure: request must hold steady while ready is low.
    stall_req = 3;
    exp_q.push_back({32'h1FC, 32'h01020304, 4'hF});
    issue_a(3'd2, 12'hFFC, 32'h200, 32'h01020304);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall cyc%0d", k),
          {a_if.mem_req_valid, a_if.mem_addr, a_if.mem_wdata, a_if.mem_be,
           a_if.in_ready, a_if.busy},
          {1'b1, 32'h1FC, 32'h01020304, 4'hF, 1'b0, 1'b1});
      @(negedge clk);
    end
    wait_end_a("stall");
    stall_req = 0;
    cmp_beats("stall");

    // Reset while waiting for the first ack of a split store.
    ack_en = 1'b0;
    d0 = done_cnt; f0 = fault_cnt; b0 = beat_cnt;
    exp_q.push_back({32'h100, 32'h34000000, 4'h8});
    issue_a(3'd1, 12'h003, 32'h100, 32'h00001234);
    t = 0;
    while (beat_cnt == b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    @(negedge clk);
    chk("rstmid busy", a_if.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid idle", {a_if.in_ready, a_if.busy, a_if.mem_req_valid, a_if.mem_be},
        {1'b1, 1'b0, 1'b0, 4'h0});
    @(negedge clk);
    tb_ack = 1'b1;
    @(negedge clk);
    tb_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid no done/fault", {done_cnt - d0, fault_cnt - f0}, 0);
    chk("rstmid stray ack", {a_if.in_ready, a_if.busy, a_if.mem_req_valid},
        {1'b1, 1'b0, 1'b0});
    cmp_beats("rstmid");
    ack_en = 1'b1;

    // No-split instance: crossing halfword faults without a request.
    b_if.instruction_code = mk_ic(3'd1, 12'h003);
    b_if.rs1_val  = 32'h100;
    b_if.rs2_val  = 32'h1234;
    b_if.in_valid = 1'b1;
    @(negedge clk);
    b_if.in_valid = 1'b0;
    chk("nosplit fault pulse", {b_if.fault, b_if.in_ready, b_if.busy}, {1'b1, 1'b0, 1'b1});
    @(negedge clk);
    chk("nosplit fault end", {b_if.fault, b_if.in_ready, b_if.busy}, {1'b0, 1'b1, 1'b0});
    repeat (4) @(negedge clk);
    chk("nosplit fault count", b_fault_cnt, 1);
    chk("nosplit no request", b_valid_cnt, 0);

    // 64-bit instance: doubleword store in one beat.
    c_if.instruction_code = mk_ic(3'd3, 12'h000);
    c_if.rs1_val  = 64'h10;
    c_if.rs2_val  = 64'h0123456789ABCDEF;
    c_if.in_valid = 1'b1;
    @(negedge clk);
    c_if.in_valid = 1'b0;
    chk("sd beat", {c_if.mem_req_valid, c_if.mem_addr, c_if.mem_wdata, c_if.mem_be},
        {1'b1, 32'h10, 64'h0123456789ABCDEF, 8'hFF});
    c_if.mem_req_ready = 1'b1;
    @(negedge clk);
    c_if.mem_req_ready = 1'b0;
    chk("sd valid drop", c_if.mem_req_valid, 0);
    c_if.mem_ack = 1'b1;
    @(negedge clk);
    c_if.mem_ack = 1'b0;
    chk("sd done", {c_if.done, c_if.in_ready, c_if.busy}, {1'b1, 1'b1, 1'b0});
    @(negedge clk);
    chk("sd done pulse", c_if.done, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Parametrised store execution unit; successor to the combinational store decoder.
- Accepts a raw S-type instruction plus register operands, decodes it, and computes the effective address.
- Aligns write data and generates byte enables, then drives a valid/ready memory write port. Misaligned stores are optionally split into two beats.
- Sits between the issue stage and the data-memory interface; at most one store in flight.

Parameters:
- XLEN, 32: operand/data width; 32 or 64.
- ADDR_W, 32: memory address width; ADDR_W <= XLEN.
- MISALIGN_SPLIT, 1: 1 = split word-crossing stores into two beats; 0 = raise fault.
- Derived (not overridable): NB = XLEN/8, OFF = log2(NB).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  store request valid
- in_ready  out  1  unit can accept a request (high only in IDLE)
- instruction_code  in  25  instruction bits [31:7]
- rs1_val  in  XLEN  base address operand
- rs2_val  in  XLEN  store data operand
- mem_req_valid  out  1  write request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  NB-aligned beat address
- mem_wdata  out  XLEN  lane-aligned write data
- mem_be  out  NB  byte enables
- mem_ack  in  1  write completion, one cycle per accepted beat
- done  out  1  one-cycle pulse when the store fully completes
- fault  out  1  one-cycle pulse for an illegal or disallowed-misaligned store
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on rising clk.
  - rst synchronous, active-high, dominates all other inputs.
  - Reset values: state = IDLE; in_ready = 1; mem_req_valid = 0; done = 0; fault = 0; busy = 0; mem_addr/mem_wdata/mem_be = 0.
  - rst in any state, including mid-request or awaiting ack, abandons the store with no done/fault pulse. Any later mem_ack is ignored.
- Decode, on the cycle with in_valid && in_ready:
  - func3 = instruction_code[14:12].
  - imm = {instruction_code[31:25], instruction_code[11:7]}, sign-extended to XLEN.
  - EA = rs1_val + sext(imm), modulo 2^XLEN; the low ADDR_W bits are used.
  - Size: func3 0 = SB (N=1), 1 = SH (N=2), 2 = SW (N=4), 3 = SD (N=8, legal only when XLEN=64).
  - Any other func3, or SD with XLEN=32, is illegal.
  - Operands are registered at accept; input changes afterwards have no effect.
- Beat formation, with o = EA[OFF-1:0]:
  - beat1: mem_addr = EA with low OFF bits cleared; mem_wdata = rs2_val << (8*o); mem_be = ((1<<N)-1) << o, truncated to NB bits.
  - Crossing condition: o + N > NB.
  - beat2 (crossing only): mem_addr = beat1 addr + NB, modulo 2^ADDR_W; mem_wdata = rs2_val >> (8*(NB-o)); mem_be = ((1<<N)-1) >> (NB-o).
- States: IDLE, REQ1, WAIT1, REQ2, WAIT2, FLT.
  - IDLE -> REQ1 on accept of a legal store that is non-crossing, or crossing with MISALIGN_SPLIT=1.
  - IDLE -> FLT on accept of an illegal store, or a crossing store with MISALIGN_SPLIT=0.
  - FLT: fault = 1 for exactly one cycle, no memory request issued, then -> IDLE.
  - REQ1/REQ2: mem_req_valid = 1. mem_addr/wdata/be held stable until mem_req_ready is sampled high, then -> WAIT1/WAIT2. mem_req_valid deasserts the cycle after acceptance.
  - WAIT1 + mem_ack: -> REQ2 if crossing; otherwise done pulse next cycle and -> IDLE.
  - WAIT2 + mem_ack: done pulse next cycle and -> IDLE.
- Edge cases:
  - mem_ack in the same cycle as request acceptance is not expected and is ignored.
  - mem_ack outside WAIT1/WAIT2 is ignored.
  - A new request is accepted at the earliest in the cycle done/fault is high (in_ready returns with IDLE).
  - No back-to-back accept while busy.

Test Plan:
- XLEN=32: SW, rs1=0x100, imm=0, rs2=0xDEADBEEF -> one beat: addr 0x100, be 4'b1111, wdata 0xDEADBEEF; done one cycle after ack.
- SB, rs1=0x100, imm=3, rs2=0x000000AB -> addr 0x100, be 4'b1000, wdata 0xAB000000.
- SH, rs1=0x100, imm=3, rs2=0x1234, MISALIGN_SPLIT=1 -> beat1: 0x100 / be 1000 / wdata 0x34000000; beat2: 0x104 / be 0001 / wdata 0x00000012; exactly one done after the second ack. Same stimulus with MISALIGN_SPLIT=0 -> single fault pulse, mem_req_valid never asserted.
- Negative imm: rs1=0x200, imm=0xFFC (-4), SW -> addr 0x1FC. Also hold mem_req_ready low for 3 cycles -> addr/wdata/be/valid stable throughout; in_ready low.
- func3=3 with XLEN=32 -> fault pulse, no request. With XLEN=64: SD, rs1=0x10, imm=0 -> be 8'hFF, one beat.
- Assert rst during WAIT1 of a split store -> next cycle IDLE, in_ready=1, no done; a stray mem_ack afterwards causes no output change.
